sweep_ctrl: RTL and testbench

Frequency-sweep sequencer that drives the control inputs (en, incr, phase_offset) of the sinegen sine generator. On a start pulse it latches a sweep configuration and steps the phase increment from a start value to a stop value in fixed-size steps. Each step is held for a programmable dwell time. It then disables the generator and pulses done. It sits between the top-level control (switches/vbuddy) and sinegen.

---
 rtl/sweep_ctrl_if.sv | 33 +++
 rtl/sweep_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_sweep_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sweep_ctrl_if.sv
// Sweep control bus between the top-level control side (master) and sweep_ctrl (slave).
// Carries the sweep request/configuration and the sinegen-facing outputs.
interface sweep_ctrl_if #(
   parameter int unsigned D_WIDTH     = 8,
   parameter int unsigned DWELL_WIDTH = 16
);

   logic                   start;
   logic                   abort;
   logic [D_WIDTH-1:0]     f_start;
   logic [D_WIDTH-1:0]     f_stop;
   logic [D_WIDTH-1:0]     f_step;
   logic [DWELL_WIDTH-1:0] dwell;
   logic [D_WIDTH-1:0]     phase_in;

   logic                   en;
   logic [D_WIDTH-1:0]     incr;
   logic [D_WIDTH-1:0]     phase_offset;
   logic                   busy;
   logic                   done;
   logic                   step_pulse;

   modport master (
      output start, abort, f_start, f_stop, f_step, dwell, phase_in,
      input  en, incr, phase_offset, busy, done, step_pulse
   );

   modport slave (
      input  start, abort, f_start, f_stop, f_step, dwell, phase_in,
      output en, incr, phase_offset, busy, done, step_pulse
   );

endinterface

// File: rtl/sweep_ctrl.sv
// Frequency-sweep sequencer stepping sinegen's incr from f_start to f_stop with a dwell per step.
// Optional: define SWEEP_LOOP_EN to restart the sweep at f_start instead of finishing.
module sweep_ctrl #(
   parameter int unsigned D_WIDTH     = 8,
   parameter int unsigned DWELL_WIDTH = 16
) (
   input logic         clk,
   input logic         rst,
   sweep_ctrl_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e                 state_q, state_d;
   logic                   en_q, en_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   step_q, step_d;
   logic [D_WIDTH-1:0]     incr_q, incr_d;
   logic [D_WIDTH-1:0]     phase_q, phase_d;
   logic [D_WIDTH-1:0]     stop_q, stop_d;
   logic [D_WIDTH-1:0]     fstep_q, fstep_d;
   logic                   up_q, up_d;
   logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
   logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
`ifdef SWEEP_LOOP_EN
   logic [D_WIDTH-1:0]     fstart_q, fstart_d;
`endif

   logic                   start_ok;
   logic                   dwell_exp;
   logic                   at_end;
   logic [DWELL_WIDTH-1:0] in_dwell_m1;
   logic [D_WIDTH:0]       sum;
   logic [D_WIDTH:0]       diff;
   logic [D_WIDTH-1:0]     next_val;

   assign start_ok    = bus.start & ~bus.abort;
   assign dwell_exp   = (cnt_q == '0);
   assign at_end      = (incr_q == stop_q) || (fstep_q == '0);
   // Counter holds cycles remaining after the current one; dwell of 0 behaves as 1.
   assign in_dwell_m1 = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_WIDTH'(1);

   always_comb begin
      sum      = {1'b0, incr_q} + {1'b0, fstep_q};
      diff     = {1'b0, incr_q} - {1'b0, fstep_q};
      next_val = stop_q;
      if (up_q) begin
         if (!sum[D_WIDTH] && (sum[D_WIDTH-1:0] <= stop_q)) begin
            next_val = sum[D_WIDTH-1:0];
         end
      end else begin
         if (!diff[D_WIDTH] && (diff[D_WIDTH-1:0] >= stop_q)) begin
            next_val = diff[D_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         en_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         step_q   <= 1'b0;
         incr_q   <= '0;
         phase_q  <= '0;
         stop_q   <= '0;
         fstep_q  <= '0;
         up_q     <= 1'b0;
         dwell_q  <= '0;
         cnt_q    <= '0;
`ifdef SWEEP_LOOP_EN
         fstart_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         en_q     <= en_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         step_q   <= step_d;
         incr_q   <= incr_d;
         phase_q  <= phase_d;
         stop_q   <= stop_d;
         fstep_q  <= fstep_d;
         up_q     <= up_d;
         dwell_q  <= dwell_d;
         cnt_q    <= cnt_d;
`ifdef SWEEP_LOOP_EN
         fstart_q <= fstart_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start_ok) begin
               state_d = StRun;
            end
         end
         StRun: begin
            // abort outranks a coincident dwell expiry
            if (bus.abort) begin
               state_d = StIdle;
            end else if (dwell_exp && at_end) begin
`ifdef SWEEP_LOOP_EN
               state_d = StRun;
`else
               state_d = StDone;
`endif
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      en_d     = (state_d == StRun);
      busy_d   = (state_d == StRun);
      done_d   = 1'b0;
      step_d   = 1'b0;
      incr_d   = incr_q;
      phase_d  = phase_q;
      stop_d   = stop_q;
      fstep_d  = fstep_q;
      up_d     = up_q;
      dwell_d  = dwell_q;
      cnt_d    = cnt_q;
`ifdef SWEEP_LOOP_EN
      fstart_d = fstart_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start_ok) begin
               incr_d   = bus.f_start;
               phase_d  = bus.phase_in;
               stop_d   = bus.f_stop;
               fstep_d  = bus.f_step;
               up_d     = (bus.f_stop >= bus.f_start);
               dwell_d  = in_dwell_m1;
               cnt_d    = in_dwell_m1;
`ifdef SWEEP_LOOP_EN
               fstart_d = bus.f_start;
`endif
            end
         end
         StRun: begin
            if (!bus.abort) begin
               if (!dwell_exp) begin
                  cnt_d = cnt_q - DWELL_WIDTH'(1);
               end else if (at_end) begin
                  done_d = 1'b1;
`ifdef SWEEP_LOOP_EN
                  incr_d = fstart_q;
                  cnt_d  = dwell_q;
`endif
               end else begin
                  incr_d = next_val;
                  cnt_d  = dwell_q;
                  step_d = 1'b1;
               end
            end
         end
         default: begin
         end
      endcase
   end

   assign bus.en           = en_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.step_pulse   = step_q;
   assign bus.incr         = incr_q;
   assign bus.phase_offset = phase_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Bench for sweep_ctrl: directed vector table plus randomized sweeps against a trace model.
// Expected per-cycle outputs come from a list of held incr values built from the sweep rules.
module tb_sweep_ctrl;

`ifdef SWEEP_LOOP_EN
   localparam bit Loop = 1'b1;
`else
   localparam bit Loop = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   sweep_ctrl_if #(.D_WIDTH(8), .DWELL_WIDTH(16)) bus ();

   sweep_ctrl #(.D_WIDTH(8), .DWELL_WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      int fs; int fe; int fp; int dw; int ph;
      int ab; int rs; int re;
      int n;  int v0; int v1; int v2; int v3;
   } vec_t;

   vec_t tbl[$];
   int   trace[$];
   bit   pulse[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [19:0] mk(input bit en, input bit busy, input bit done,
                                      input bit step, input int incr, input int ph);
      logic [7:0] i8;
      logic [7:0] p8;
      i8 = incr[7:0];
      p8 = ph[7:0];
      return {en, busy, done, step, i8, p8};
   endfunction

   function automatic logic [19:0] act();
      return {bus.en, bus.busy, bus.done, bus.step_pulse, bus.incr, bus.phase_offset};
   endfunction

   task automatic check(input string name, input int c, input logic [19:0] exp);
      logic [19:0] a;
      a = act();
      checks++;
      if (a !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got en=%b busy=%b done=%b step=%b incr=%0d phase=%0d, expected en=%b busy=%b done=%b step=%b incr=%0d phase=%0d",
                  name, c, a[19], a[18], a[17], a[16], a[15:8], a[7:0],
                  exp[19], exp[18], exp[17], exp[16], exp[15:8], exp[7:0]);
      end
   endtask

   function automatic void add_vec(int fs, int fe, int fp, int dw, int ph, int ab, int rs,
                                   int re, int n, int v0, int v1, int v2, int v3);
      vec_t t;
      t.fs = fs; t.fe = fe; t.fp = fp; t.dw = dw; t.ph = ph;
      t.ab = ab; t.rs = rs; t.re = re;
      t.n = n; t.v0 = v0; t.v1 = v1; t.v2 = v2; t.v3 = v3;
      tbl.push_back(t);
   endfunction

   function automatic void push_hold(int v, int dw, bit first);
      int d;
      d = (dw == 0) ? 1 : dw;
      for (int k = 0; k < d; k++) begin
         trace.push_back(v);
         pulse.push_back((k == 0) && !first);
      end
   endfunction

   function automatic void build_from_list(vec_t t);
      int vals[4];
      vals[0] = t.v0; vals[1] = t.v1; vals[2] = t.v2; vals[3] = t.v3;
      trace.delete();
      pulse.delete();
      for (int i = 0; i < t.n; i++) push_hold(vals[i], t.dw, i == 0);
   endfunction

   // Values held in order: start, then step toward stop, clamped, until stop or zero step.
   function automatic void build_from_model(int fs, int fe, int fp, int dw);
      int v;
      bit first;
      v = fs;
      first = 1'b1;
      trace.delete();
      pulse.delete();
      forever begin
         push_hold(v, dw, first);
         first = 1'b0;
         if (v == fe || fp == 0) break;
         if (fe >= fs) v = (v + fp > fe) ? fe : v + fp;
         else          v = (v - fp < fe) ? fe : v - fp;
      end
   endfunction

   task automatic run_case(input string name, input int fs, input int fe, input int fp,
                           input int dw, input int ph, input int ab, input int rs_at,
                           input int re_at);
      int l;
      int a;
      int idx;
      l = trace.size();
      a = ab;
      if (Loop && a < 0 && rs_at < 0) a = 2 * l + 1;
      bus.f_start  = fs[7:0];
      bus.f_stop   = fe[7:0];
      bus.f_step   = fp[7:0];
      bus.dwell    = dw[15:0];
      bus.phase_in = ph[7:0];
      bus.start    = 1'b1;
      tick();
      bus.start    = 1'b0;
      bus.f_start  = 8'($urandom);
      bus.f_stop   = 8'($urandom);
      bus.f_step   = 8'($urandom);
      bus.dwell    = 16'($urandom_range(0, 5));
      bus.phase_in = 8'($urandom);
      for (int c = 1; c <= 4 * l + 4; c++) begin
         idx = (c - 1) % l;
         if (rs_at > 0 && c == rs_at + 1) begin
            check({name, "/rst"}, c, mk(0, 0, 0, 0, 0, 0));
            break;
         end
         if (a > 0 && c == a + 1) begin
            check({name, "/abort"}, c, mk(0, 0, 0, 0, trace[(a - 1) % l], ph));
            break;
         end
         if (!Loop && c == l + 1) begin
            check({name, "/done"}, c, mk(0, 0, 1, 0, trace[l - 1], ph));
         end else if (!Loop && c == l + 2) begin
            check({name, "/idle"}, c, mk(0, 0, 0, 0, trace[l - 1], ph));
            break;
         end else begin
            check({name, "/run"}, c, mk(1, 1, Loop && c > 1 && idx == 0, pulse[idx],
                                         trace[idx], ph));
         end
         bus.abort = (c == a);
         rst       = (c == rs_at);
         bus.start = (c == re_at);
         tick();
      end
      bus.abort = 1'b0;
      bus.start = 1'b0;
      rst       = 1'b0;
   endtask

   initial begin
      bus.start = 1'b0; bus.abort = 1'b0;
      bus.f_start = '0; bus.f_stop = '0; bus.f_step = '0; bus.dwell = '0; bus.phase_in = '0;
      rst = 1'b1;
      tick();
      check("reset", 0, mk(0, 0, 0, 0, 0, 0));
      tick();
      rst = 1'b0;

      // start and abort together in idle: sweep must not begin
      bus.f_start = 8'd33; bus.f_stop = 8'd40; bus.f_step = 8'd1; bus.dwell = 16'd2;
      bus.phase_in = 8'd9;
      bus.start = 1'b1; bus.abort = 1'b1;
      tick();
      bus.start = 1'b0; bus.abort = 1'b0;
      check("start_abort", 1, mk(0, 0, 0, 0, 0, 0));
      tick();
      check("start_abort", 2, mk(0, 0, 0, 0, 0, 0));

      //      fs   fe   fp dw  ph  abort rst restart n  values
      add_vec(4,   16,  4, 3,  64, -1,   -1, -1,     4, 4,   8,   12,  16);
      add_vec(200, 190, 4, 1,  17, -1,   -1, -1,     4, 200, 196, 192, 190);
      add_vec(250, 255, 4, 2,  3,  -1,   -1, -1,     3, 250, 254, 255, 0);
      add_vec(4,   16,  4, 3,  64, 5,    -1, 2,      4, 4,   8,   12,  16);
      add_vec(10,  99,  0, 0,  5,  -1,   -1, -1,     1, 10,  0,   0,   0);
      add_vec(4,   16,  4, 3,  64, -1,   3,  -1,     4, 4,   8,   12,  16);
      add_vec(77,  77,  5, 2,  128, -1,  -1, -1,     1, 77,  0,   0,   0);
      add_vec(5,   0,   3, 1,  255, -1,  -1, -1,     3, 5,   2,   0,   0);

      foreach (tbl[i]) begin
         build_from_list(tbl[i]);
         run_case($sformatf("vec%0d", i), tbl[i].fs, tbl[i].fe, tbl[i].fp, tbl[i].dw,
                  tbl[i].ph, tbl[i].ab, tbl[i].rs, tbl[i].re);
      end

      for (int r = 0; r < 30; r++) begin
         int fs, fe, fp, dw, ph, ab, re, l;
         fs = $urandom_range(0, 255);
         fe = $urandom_range(0, 255);
         fp = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 40);
         dw = $urandom_range(0, 3);
         ph = $urandom_range(0, 255);
         build_from_model(fs, fe, fp, dw);
         l  = trace.size();
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, l) : -1;
         re = ($urandom_range(0, 3) == 0) ? $urandom_range(1, l) : -1;
         run_case($sformatf("rand%0d", r), fs, fe, fp, dw, ph, ab, -1, re);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
